// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered issue queue in front of the ALU. Captures operands from the CDB and
// issues the oldest ready op each cycle through registered outputs.
module alu_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [6:0]       disp_opcode,
    input  logic [2:0]       disp_func3,
    input  logic [6:0]       disp_func7,
    input  logic [TAG_W-1:0] disp_pd,
    input  logic [TAG_W-1:0] disp_s1_tag,
    input  logic             disp_s1_rdy,
    input  logic [XLEN-1:0]  disp_s1_val,
    input  logic [TAG_W-1:0] disp_s2_tag,
    input  logic             disp_s2_rdy,
    input  logic [XLEN-1:0]  disp_s2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             iss_valid,
    output logic [6:0]       iss_opcode,
    output logic [2:0]       iss_func3,
    output logic [6:0]       iss_func7,
    output logic [XLEN-1:0]  iss_source_1,
    output logic [XLEN-1:0]  iss_source_2,
    output logic [TAG_W-1:0] iss_pd,
    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic             valid;
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [TAG_W-1:0] pd;
        logic [TAG_W-1:0] s1_tag;
        logic             s1_rdy;
        logic [XLEN-1:0]  s1_val;
        logic [TAG_W-1:0] s2_tag;
        logic             s2_rdy;
        logic [XLEN-1:0]  s2_val;
    } entry_t;

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    entry_t          woken     [DEPTH];
    entry_t          sel_entry;
    entry_t          new_entry;
    logic            sel_found;
    int unsigned     sel_idx;
    logic            cdb_hit;
    logic            do_disp;
    logic [CW-1:0]   disp_idx;
    logic [CW-1:0]   count_q, count_d;

    logic             iss_valid_q;
    logic [6:0]       iss_opcode_q;
    logic [2:0]       iss_func3_q;
    logic [6:0]       iss_func7_q;
    logic [XLEN-1:0]  iss_source_1_q;
    logic [XLEN-1:0]  iss_source_2_q;
    logic [TAG_W-1:0] iss_pd_q;

    function automatic entry_t wake(entry_t e, logic hit, logic [TAG_W-1:0] tag,
                                    logic [XLEN-1:0] data);
        entry_t r;
        r = e;
        if (hit && e.valid && !e.s1_rdy && e.s1_tag == tag) begin
            r.s1_rdy = 1'b1;
            r.s1_val = data;
        end
        if (hit && e.valid && !e.s2_rdy && e.s2_tag == tag) begin
            r.s2_rdy = 1'b1;
            r.s2_val = data;
        end
        return r;
    endfunction

    assign cdb_hit    = cdb_valid && (cdb_tag != '0);
    assign disp_ready = (count_q < DepthC);
    assign do_disp    = disp_valid && disp_ready;
    assign count      = count_q;

    // Select looks only at registered readiness; a same-cycle CDB match waits a cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 0;
        sel_entry = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (entries_q[i].valid && entries_q[i].s1_rdy && entries_q[i].s2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = i;
                sel_entry = entries_q[i];
            end
        end
    end

    always_comb begin
        new_entry        = '0;
        new_entry.valid  = 1'b1;
        new_entry.opcode = disp_opcode;
        new_entry.func3  = disp_func3;
        new_entry.func7  = disp_func7;
        new_entry.pd     = disp_pd;
        new_entry.s1_tag = disp_s1_tag;
        new_entry.s1_rdy = disp_s1_rdy;
        new_entry.s1_val = disp_s1_val;
        new_entry.s2_tag = disp_s2_tag;
        new_entry.s2_rdy = disp_s2_rdy;
        new_entry.s2_val = disp_s2_val;
        new_entry        = wake(new_entry, cdb_hit, cdb_tag, cdb_data);
    end

    // Wakeup is applied before the collapse so shifted entries carry captured values.
    always_comb begin
        disp_idx = count_q - CW'(sel_found);
        for (int i = 0; i < int'(DEPTH); i++) begin
            woken[i] = wake(entries_q[i], cdb_hit, cdb_tag, cdb_data);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_d[i] = woken[i];
            if (sel_found && i >= int'(sel_idx)) begin
                entries_d[i] = (i < int'(DEPTH) - 1) ? woken[i+1] : '0;
            end
            if (do_disp && CW'(i) == disp_idx) begin
                entries_d[i] = new_entry;
            end
            if (flush) begin
                entries_d[i] = '0;
            end
        end
        count_d = flush ? '0 : count_q + CW'(do_disp) - CW'(sel_found);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q    <= 1'b0;
            iss_opcode_q   <= '0;
            iss_func3_q    <= '0;
            iss_func7_q    <= '0;
            iss_source_1_q <= '0;
            iss_source_2_q <= '0;
            iss_pd_q       <= '0;
        end else begin
            iss_valid_q <= sel_found && !flush;
            if (sel_found && !flush) begin
                iss_opcode_q   <= sel_entry.opcode;
                iss_func3_q    <= sel_entry.func3;
                iss_func7_q    <= sel_entry.func7;
                iss_source_1_q <= sel_entry.s1_val;
                iss_source_2_q <= sel_entry.s2_val;
                iss_pd_q       <= sel_entry.pd;
            end
        end
    end

    assign iss_valid    = iss_valid_q;
    assign iss_opcode   = iss_opcode_q;
    assign iss_func3    = iss_func3_q;
    assign iss_func7    = iss_func7_q;
    assign iss_source_1 = iss_source_1_q;
    assign iss_source_2 = iss_source_2_q;
    assign iss_pd       = iss_pd_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: expected issues are queued at stimulus time and checked in
// order by a negedge monitor; scenario tasks add inline timing checks.
module tb_alu_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [XLEN-1:0]  s1;
        logic [XLEN-1:0]  s2;
        logic [TAG_W-1:0] pd;
    } iss_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [6:0]       disp_opcode;
    logic [2:0]       disp_func3;
    logic [6:0]       disp_func7;
    logic [TAG_W-1:0] disp_pd;
    logic [TAG_W-1:0] disp_s1_tag;
    logic             disp_s1_rdy;
    logic [XLEN-1:0]  disp_s1_val;
    logic [TAG_W-1:0] disp_s2_tag;
    logic             disp_s2_rdy;
    logic [XLEN-1:0]  disp_s2_val;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             iss_valid;
    logic [6:0]       iss_opcode;
    logic [2:0]       iss_func3;
    logic [6:0]       iss_func7;
    logic [XLEN-1:0]  iss_source_1;
    logic [XLEN-1:0]  iss_source_2;
    logic [TAG_W-1:0] iss_pd;
    logic [3:0]       count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    iss_t exp_q[$];

    localparam logic [6:0] OpR = 7'b0110011;
    localparam logic [6:0] OpI = 7'b0010011;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_opcode (disp_opcode),
        .disp_func3  (disp_func3),
        .disp_func7  (disp_func7),
        .disp_pd     (disp_pd),
        .disp_s1_tag (disp_s1_tag),
        .disp_s1_rdy (disp_s1_rdy),
        .disp_s1_val (disp_s1_val),
        .disp_s2_tag (disp_s2_tag),
        .disp_s2_rdy (disp_s2_rdy),
        .disp_s2_val (disp_s2_val),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .iss_valid   (iss_valid),
        .iss_opcode  (iss_opcode),
        .iss_func3   (iss_func3),
        .iss_func7   (iss_func7),
        .iss_source_1(iss_source_1),
        .iss_source_2(iss_source_2),
        .iss_pd      (iss_pd),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && iss_valid === 1'b1) begin
            iss_t got;
            iss_t e;
            got = '{iss_opcode, iss_func3, iss_func7, iss_source_1, iss_source_2, iss_pd};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got %h required no issue", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL issue_fields: got %h required %h", got, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic exp_push(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                            input logic [TAG_W-1:0] pd);
        exp_q.push_back('{op, f3, f7, s1, s2, pd});
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [TAG_W-1:0] pd,
                        input logic [TAG_W-1:0] t1, input logic r1, input logic [XLEN-1:0] v1,
                        input logic [TAG_W-1:0] t2, input logic r2, input logic [XLEN-1:0] v2);
        disp_valid  = 1'b1;
        disp_opcode = op;
        disp_func3  = f3;
        disp_func7  = f7;
        disp_pd     = pd;
        disp_s1_tag = t1;
        disp_s1_rdy = r1;
        disp_s1_val = v1;
        disp_s2_tag = t2;
        disp_s2_rdy = r2;
        disp_s2_val = v2;
        tick();
        disp_valid  = 1'b0;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tick();
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_iss_valid", 32'(iss_valid), 32'd0);
        chk("reset_iss_pd", 32'(iss_pd), 32'd0);
        chk("reset_iss_src1", iss_source_1, 32'd0);
        chk("reset_disp_ready", 32'(disp_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        exp_push(OpR, 3'b000, 7'd0, 32'd10, 32'd3, 6'd5);
        disp(OpR, 3'b000, 7'd0, 6'd5, 6'd0, 1'b1, 32'd10, 6'd0, 1'b1, 32'd3);
        chk("basic_no_issue_yet", 32'(iss_valid), 32'd0);
        chk("basic_count_1", 32'(count), 32'd1);
        tick();
        chk("basic_issue", 32'(iss_valid), 32'd1);
        chk("basic_count_0", 32'(count), 32'd0);
        drain("basic");
    endtask

    task automatic test_wakeup();
        exp_push(OpR, 3'b000, 7'h20, 32'd100, 32'h20, 6'd6);
        disp(OpR, 3'b000, 7'h20, 6'd6, 6'd0, 1'b1, 32'd100, 6'd7, 1'b0, 32'd0);
        chk("wake_wait_1", 32'(iss_valid), 32'd0);
        tick();
        chk("wake_wait_2", 32'(iss_valid), 32'd0);
        cdb(6'd7, 32'h20);
        chk("wake_not_same_edge", 32'(iss_valid), 32'd0);
        tick();
        chk("wake_issue", 32'(iss_valid), 32'd1);
        chk("wake_src2", iss_source_2, 32'h20);
        drain("wake");
    endtask

    task automatic test_forward();
        exp_push(OpR, 3'b100, 7'd0, 32'hAB, 32'd1, 6'd8);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_data  = 32'hAB;
        disp(OpR, 3'b100, 7'd0, 6'd8, 6'd9, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
        cdb_valid = 1'b0;
        chk("fwd_no_issue_yet", 32'(iss_valid), 32'd0);
        tick();
        chk("fwd_issue", 32'(iss_valid), 32'd1);
        chk("fwd_src1", iss_source_1, 32'hAB);
        drain("fwd");
    endtask

    task automatic test_full();
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_push(OpR, 3'b000, 7'd0, 32'(i + 40), 32'h55, 6'(i + 1));
            disp(OpR, 3'b000, 7'd0, 6'(i + 1), 6'd0, 1'b1, 32'(i + 40), 6'd12, 1'b0, 32'd0);
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_not_ready", 32'(disp_ready), 32'd0);
        disp(OpR, 3'b000, 7'd0, 6'd31, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
        chk("full_drop_count", 32'(count), 32'd8);
        cdb(6'd0, 32'hDEAD);
        chk("full_tag0_ignored", 32'(iss_valid), 32'd0);
        cdb(6'd12, 32'h55);
        chk("full_wake_count", 32'(count), 32'd8);
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick();
            chk("full_issue_each_cycle", 32'(iss_valid), 32'd1);
            chk("full_count_down", 32'(count), 32'(int'(DEPTH) - 1 - i));
        end
        drain("full");
    endtask

    task automatic test_age();
        exp_push(OpI, 3'b000, 7'd0, 32'd7, 32'd5, 6'd11);
        exp_push(OpR, 3'b100, 7'd0, 32'hF0, 32'h0F, 6'd12);
        exp_push(OpR, 3'b000, 7'd0, 32'h33, 32'd4, 6'd10);
        disp(OpR, 3'b000, 7'd0, 6'd10, 6'd3, 1'b0, 32'd0, 6'd0, 1'b1, 32'd4);
        disp(OpI, 3'b000, 7'd0, 6'd11, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd5);
        disp(OpR, 3'b100, 7'd0, 6'd12, 6'd0, 1'b1, 32'hF0, 6'd0, 1'b1, 32'h0F);
        chk("age_first_pd", 32'(iss_pd), 32'd11);
        chk("age_count_disp_and_issue", 32'(count), 32'd2);
        tick();
        chk("age_second_pd", 32'(iss_pd), 32'd12);
        tick();
        chk("age_blocked_idle", 32'(iss_valid), 32'd0);
        cdb(6'd3, 32'h33);
        tick();
        chk("age_oldest_pd", 32'(iss_pd), 32'd10);
        drain("age");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            disp(OpR, 3'b000, 7'd0, 6'(i + 20), 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
        end
        disp(OpR, 3'b000, 7'd0, 6'd24, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
        chk("flush_pre_count", 32'(count), 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_iss_valid", 32'(iss_valid), 32'd0);
        cdb(6'd20, 32'd9);
        tick();
        chk("flush_no_late_issue", 32'(iss_valid), 32'd0);
    endtask

    task automatic test_async_reset();
        disp(OpR, 3'b000, 7'd0, 6'd30, 6'd21, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
        exp_push(OpR, 3'b000, 7'd0, 32'd2, 32'd3, 6'd9);
        disp(OpR, 3'b000, 7'd0, 6'd9, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd3);
        disp(OpR, 3'b000, 7'd0, 6'd31, 6'd21, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
        chk("arst_pre_issue", 32'(iss_valid), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_iss_valid", 32'(iss_valid), 32'd0);
        chk("arst_iss_pd", 32'(iss_pd), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        cdb(6'd21, 32'd5);
        tick();
        chk("arst_no_issue_after", 32'(iss_valid), 32'd0);
        chk("arst_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        disp_valid  = 1'b0;
        disp_opcode = '0;
        disp_func3  = '0;
        disp_func7  = '0;
        disp_pd     = '0;
        disp_s1_tag = '0;
        disp_s1_rdy = 1'b0;
        disp_s1_val = '0;
        disp_s2_tag = '0;
        disp_s2_rdy = 1'b0;
        disp_s2_val = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_data    = '0;
        test_reset();
        tick();
        test_basic();
        test_wakeup();
        test_forward();
        test_full();
        test_age();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
